// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   N-master to 1-slave classic Wishbone round-robin arbiter. The grant is
//   locked for a whole bus cycle (m_cyc_i high). There is one dead cycle
//   between owners. Acks pass straight through with no added latency.
//
//   Optional feature macro: WB_ARB_TIMEOUT_EN
//     When it is defined, an owner whose strobe goes unacked for
//     TIMEOUT_CYCLES cycles receives a one-cycle m_err_o pulse. The slave is
//     then released, and the arbiter waits in DRAIN until that owner drops
//     m_cyc_i.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among m_cyc_i requests
//   GRANT | granted master drives the slave until it drops m_cyc_i
//   DRAIN | (timeout build only) slave abandoned; wait for owner to drop cyc
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SW             = DW / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*SW-1:0] m_sel_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [DW-1:0]             m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [SW-1:0]             s_sel_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  input  logic                      s_ack_i,
  input  logic [DW-1:0]             s_dat_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      busy_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1
  } state_t;
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [PW-1:0]          r_ptr;
  logic [PW-1:0]          w_ptr_nxt;

  logic                   w_found;
  logic [PW-1:0]          w_win;

  logic                   w_g_cyc;
  logic                   w_g_stb;
  logic                   w_g_we;
  logic [SW-1:0]          w_g_sel;
  logic [AW-1:0]          w_g_adr;
  logic [DW-1:0]          w_g_dat;

  logic                   w_in_grant;
  logic                   w_stb;
  logic                   w_ack;
  logic                   w_timeout;

  // Round-robin pick: first requester above the last winner, then wrap to the lowest index.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && m_cyc_i[i] && (i > int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = PW'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && m_cyc_i[i] && (i <= int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = PW'(i);
      end
    end
  end

  // Mux the owner's request signals, selected by the one-hot grant (all zero when idle).
  always_comb begin
    w_g_cyc = 1'b0;
    w_g_stb = 1'b0;
    w_g_we  = 1'b0;
    w_g_sel = '0;
    w_g_adr = '0;
    w_g_dat = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) begin
        w_g_cyc = m_cyc_i[i];
        w_g_stb = m_stb_i[i];
        w_g_we  = m_we_i[i];
        w_g_sel = m_sel_i[i*SW +: SW];
        w_g_adr = m_adr_i[i*AW +: AW];
        w_g_dat = m_dat_i[i*DW +: DW];
      end
    end
  end

  assign w_in_grant = (r_state == S_GRANT);
  assign w_stb      = w_in_grant & w_g_stb & ~w_timeout;
  assign w_ack      = w_stb & s_ack_i;

  // Next-state logic. A new owner is chosen only from IDLE, which gives the dead cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt        = S_GRANT;
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_ptr_nxt          = w_win;
        end
      end
      S_GRANT: begin
`ifdef WB_ARB_TIMEOUT_EN
        if (w_timeout) begin
          w_state_nxt = S_DRAIN;
        end else
`endif
        if (!w_g_cyc) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      S_DRAIN: begin
        if (!w_g_cyc) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers; the pointer resets so master 0 wins first.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;

  // The timeout fires on the strobe cycle that would be the TIMEOUT_CYCLES-th without an ack.
  assign w_timeout = w_in_grant & w_g_stb & (r_to_cnt == TO_LAST);

  // Count unacked strobe cycles of the current owner; restart on any ack or state change.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_to_cnt <= '0;
    end else if (w_ack || (w_state_nxt != r_state)) begin
      r_to_cnt <= '0;
    end else if (w_stb) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign m_err_o = r_grant & {NUM_MASTERS{w_timeout}};
`else
  assign w_timeout = 1'b0;
  assign m_err_o   = '0;
`endif

  // Slave side follows the owner only while in GRANT; a timeout forces cyc/stb low.
  assign s_cyc_o = w_in_grant & w_g_cyc & ~w_timeout;
  assign s_stb_o = w_stb;
  assign s_we_o  = w_in_grant & w_g_we;
  assign s_sel_o = w_in_grant ? w_g_sel : '0;
  assign s_adr_o = w_in_grant ? w_g_adr : '0;
  assign s_dat_o = w_in_grant ? w_g_dat : '0;

  assign m_ack_o = r_grant & {NUM_MASTERS{w_ack}};
  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;
  assign busy_o  = |r_grant;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed test of wb_rr_arbiter with three masters.
// The stimulus queues the expected grants and acks. An independent monitor
// compares them whenever the DUT shows a new grant or an ack/err.
module tb_wb_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    m_cyc = '0;
  logic [N-1:0]    m_stb = '0;
  logic [N-1:0]    m_we  = '0;
  logic [N*SW-1:0] m_sel = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;
  logic [DW-1:0]   m_rdat;
  logic            s_cyc, s_stb, s_we;
  logic [SW-1:0]   s_sel;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_wdat;
  logic            s_ack;
  logic [DW-1:0]   s_rdat = '0;
  logic [N-1:0]    grant;
  logic            busy;

  wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_ack_o(m_ack), .m_err_o(m_err),
    .m_dat_o(m_rdat), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack),
    .s_dat_i(s_rdat), .grant_o(grant), .busy_o(busy)
  );

  // Slave model: acks after wait_n unacked strobe cycles; stray_ack injects a spurious ack.
  int   wait_n    = 0;
  int   wcnt      = 0;
  logic stray_ack = 1'b0;
  always @(posedge clk) begin
    if (!s_stb || s_ack) wcnt <= 0;
    else                 wcnt <= wcnt + 1;
  end
  assign s_ack = (s_stb && (wcnt == wait_n)) || stray_ack;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues.
  typedef struct {
    logic [N-1:0]  grant;
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic [DW-1:0] rdat;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic          we;
    logic [SW-1:0] sel;
  } exp_t;
  typedef struct {
    logic [N-1:0] grant;
    int           idle;
  } gexp_t;
  exp_t  eq[$];
  gexp_t gq[$];

  // Master models.
  typedef struct {
    int            id;
    int            beats;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          we;
    logic [SW-1:0] sel;
  } job_t;
  job_t jobs[$];

  logic          act   [N];
  int            beats [N];
  int            hold  [N];
  logic [AW-1:0] cadr  [N];
  logic [DW-1:0] cdat  [N];
  logic          cwe   [N];
  logic [SW-1:0] csel  [N];

  task automatic step_masters();
    for (int k = 0; k < N; k++) begin
      if (act[k]) begin
        if (hold[k] > 0) begin
          hold[k]--;
          if (hold[k] == 0) act[k] = 1'b0;
        end else if (m_err[k]) begin
          hold[k] = 2;
        end else if (m_ack[k]) begin
          beats[k]--;
          cadr[k] = cadr[k] + 32'd4;
          cdat[k] = cdat[k] + 32'd1;
          if (beats[k] == 0) act[k] = 1'b0;
        end
      end else begin
        int sel_j;
        sel_j = -1;
        for (int j = 0; j < jobs.size(); j++)
          if (sel_j < 0 && jobs[j].id == k) sel_j = j;
        if (sel_j >= 0) begin
          act[k]   = 1'b1;
          beats[k] = jobs[sel_j].beats;
          hold[k]  = 0;
          cadr[k]  = jobs[sel_j].adr;
          cdat[k]  = jobs[sel_j].dat;
          cwe[k]   = jobs[sel_j].we;
          csel[k]  = jobs[sel_j].sel;
          jobs.delete(sel_j);
        end
      end
      m_cyc[k]           = act[k];
      m_stb[k]           = act[k] && (hold[k] == 0);
      m_we[k]            = act[k] && cwe[k];
      m_sel[k*SW +: SW]  = csel[k];
      m_adr[k*AW +: AW]  = cadr[k];
      m_dat[k*DW +: DW]  = cdat[k];
    end
  endtask

  function automatic logic any_act();
    logic r;
    r = 1'b0;
    for (int k = 0; k < N; k++) r = r | act[k];
    return r;
  endfunction

  task automatic abort_all();
    jobs.delete();
    for (int k = 0; k < N; k++) begin
      act[k]  = 1'b0;
      hold[k] = 0;
    end
    m_cyc = '0;
    m_stb = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
    step_masters();
  endtask

  task automatic wait_done(input int budget, input string name);
    int c;
    c = 0;
    while ((jobs.size() != 0 || any_act() || grant != '0 || eq.size() != 0 || gq.size() != 0)
           && c < budget) begin
      tick();
      c++;
    end
    chk({name, "_completes_in_budget"}, 64'(c < budget), 64'd1);
  endtask

  task automatic add_job(input int id, input int nb, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic we, input logic [SW-1:0] sel);
    job_t j;
    j.id = id; j.beats = nb; j.adr = adr; j.dat = dat; j.we = we; j.sel = sel;
    jobs.push_back(j);
  endtask

  task automatic exp_ack(input logic [N-1:0] g, input logic [N-1:0] a, input logic [N-1:0] e,
                         input logic [DW-1:0] rd, input logic [AW-1:0] adr,
                         input logic [DW-1:0] wd, input logic we, input logic [SW-1:0] sel);
    exp_t x;
    x.grant = g; x.ack = a; x.err = e; x.rdat = rd; x.adr = adr; x.wdat = wd; x.we = we; x.sel = sel;
    eq.push_back(x);
  endtask

  task automatic exp_grant(input logic [N-1:0] g, input int idle);
    gexp_t x;
    x.grant = g; x.idle = idle;
    gq.push_back(x);
  endtask

  // Monitor: checks each new grant and each ack/err cycle against the queued expectations.
  logic [N-1:0] prev_g   = '0;
  int           idle_cnt = 0;
  always @(negedge clk) begin
    exp_t  e;
    gexp_t g;
    if (grant != '0 && grant != prev_g) begin
      if (gq.size() == 0) begin
        chk("grant_unexpected", 64'(grant), 64'd0);
      end else begin
        g = gq.pop_front();
        chk("grant_order", 64'(grant), 64'(g.grant));
        chk("dead_cycle_before_grant", 64'(prev_g), 64'd0);
        if (g.idle >= 0) chk("idle_gap", 64'(idle_cnt), 64'(g.idle));
      end
    end
    if (m_ack != '0 || m_err != '0) begin
      if (eq.size() == 0) begin
        chk("ack_err_unexpected", 64'({m_err, m_ack}), 64'd0);
      end else begin
        e = eq.pop_front();
        chk("m_ack_o", 64'(m_ack), 64'(e.ack));
        chk("m_err_o", 64'(m_err), 64'(e.err));
        chk("grant_at_ack", 64'(grant), 64'(e.grant));
        chk("m_dat_o", 64'(m_rdat), 64'(e.rdat));
        chk("s_adr_o", 64'(s_adr), 64'(e.adr));
        chk("s_dat_o", 64'(s_wdat), 64'(e.wdat));
        chk("s_we_o", 64'(s_we), 64'(e.we));
        chk("s_sel_o", 64'(s_sel), 64'(e.sel));
      end
    end
    if (grant == '0) idle_cnt = idle_cnt + 1;
    else             idle_cnt = 0;
    prev_g = grant;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      act[k] = 1'b0; beats[k] = 0; hold[k] = 0;
      cadr[k] = '0; cdat[k] = '0; cwe[k] = 1'b0; csel[k] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    @(negedge clk); #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("rst_s_stb", 64'(s_stb), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_s_adr", 64'(s_adr), 64'd0);
    #1 rst = 1'b0;

    // Single write from master 1 with one wait state.
    wait_n = 1;
    s_rdat = 32'h1234_5678;
    add_job(1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF);
    exp_grant(3'b010, -1);
    exp_ack(3'b010, 3'b010, 3'b000, 32'h1234_5678, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'hF);
    tick();
    @(negedge clk); #1;
    chk("lat_grant", 64'(grant), 64'b010);
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_s_cyc", 64'(s_cyc), 64'd1);
    chk("lat_s_adr", 64'(s_adr), 64'h1000);
    chk("lat_s_dat", 64'(s_wdat), 64'hDEAD_BEEF);
    chk("lat_no_early_ack", 64'(m_ack), 64'd0);
    #1 step_masters();
    wait_done(50, "single_write");

    // Ack while idle is ignored.
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("idle_ack_ignored", 64'(m_ack), 64'd0);
      #1 step_masters();
    end
    stray_ack = 1'b0;

    // Read data broadcast to master 1.
    wait_n = 0;
    s_rdat = 32'hCAFE_0001;
    add_job(1, 1, 32'h0000_2000, 32'h0, 1'b0, 4'h3);
    exp_grant(3'b010, -1);
    exp_ack(3'b010, 3'b010, 3'b000, 32'hCAFE_0001, 32'h0000_2000, 32'h0, 1'b0, 4'h3);
    wait_done(50, "read");

    // Reset in the middle of a hung transfer.
    wait_n = 50;
    add_job(1, 1, 32'h0000_3000, 32'h55, 1'b1, 4'hF);
    exp_grant(3'b010, -1);
    repeat (4) tick();
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_s_cyc", 64'(s_cyc), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ack", 64'(m_ack), 64'd0);
    chk("midrst_err", 64'(m_err), 64'd0);
    #1;
    rst = 1'b0;
    abort_all();
    wait_n = 0;

    // Three masters requesting continuously: order 0,1,2,0,1,2, master 0 first after reset.
    s_rdat = 32'h0BAD_F00D;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < N; k++) begin
        add_job(k, 1, 32'h100 * (k + 1) + 32'h10 * c, 32'hA000_0000 | (k << 8) | c,
                k != 1, (k == 0) ? 4'hF : (k == 1) ? 4'h3 : 4'hC);
        exp_grant(3'b001 << k, (c == 0 && k == 0) ? -1 : 1);
        exp_ack(3'b001 << k, 3'b001 << k, 3'b000, 32'h0BAD_F00D,
                32'h100 * (k + 1) + 32'h10 * c, 32'hA000_0000 | (k << 8) | c,
                k != 1, (k == 0) ? 4'hF : (k == 1) ? 4'h3 : 4'hC);
      end
    end
    wait_done(100, "round_robin");

    // Cycle lock: master 0 does four back-to-back strobes while master 2 waits.
    add_job(0, 4, 32'h0000_4000, 32'h40, 1'b1, 4'hF);
    add_job(2, 1, 32'h0000_5000, 32'h50, 1'b0, 4'h1);
    exp_grant(3'b001, -1);
    exp_ack(3'b001, 3'b001, 3'b000, 32'h0BAD_F00D, 32'h4000, 32'h40, 1'b1, 4'hF);
    exp_ack(3'b001, 3'b001, 3'b000, 32'h0BAD_F00D, 32'h4004, 32'h41, 1'b1, 4'hF);
    exp_ack(3'b001, 3'b001, 3'b000, 32'h0BAD_F00D, 32'h4008, 32'h42, 1'b1, 4'hF);
    exp_ack(3'b001, 3'b001, 3'b000, 32'h0BAD_F00D, 32'h400C, 32'h43, 1'b1, 4'hF);
    exp_grant(3'b100, 1);
    exp_ack(3'b100, 3'b100, 3'b000, 32'h0BAD_F00D, 32'h5000, 32'h50, 1'b0, 4'h1);
    wait_done(100, "cycle_lock");

    // Lone persistent requester is re-granted after one dead cycle.
    add_job(1, 1, 32'h0000_6000, 32'h60, 1'b1, 4'hF);
    add_job(1, 1, 32'h0000_6010, 32'h61, 1'b1, 4'hF);
    exp_grant(3'b010, -1);
    exp_ack(3'b010, 3'b010, 3'b000, 32'h0BAD_F00D, 32'h6000, 32'h60, 1'b1, 4'hF);
    exp_grant(3'b010, 1);
    exp_ack(3'b010, 3'b010, 3'b000, 32'h0BAD_F00D, 32'h6010, 32'h61, 1'b1, 4'hF);
    wait_done(100, "re_grant");

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: err on the 8th unacked strobe cycle, then drain until cyc falls.
    wait_n = 1000;
    add_job(0, 1, 32'h0000_7000, 32'h77, 1'b1, 4'hF);
    exp_grant(3'b001, -1);
    exp_ack(3'b001, 3'b000, 3'b001, 32'h0BAD_F00D, 32'h7000, 32'h77, 1'b1, 4'hF);
    tick();
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk); #1;
      if (i < TO) begin
        chk("to_no_err_yet", 64'(m_err), 64'd0);
        chk("to_stb_high", 64'(s_stb), 64'd1);
      end else begin
        chk("to_err_pulse", 64'(m_err), 64'b001);
        chk("to_stb_dropped", 64'(s_stb), 64'd0);
        chk("to_cyc_dropped", 64'(s_cyc), 64'd0);
      end
      #1 step_masters();
    end
    @(negedge clk); #1;
    chk("drain_grant_held", 64'(grant), 64'b001);
    chk("drain_s_cyc", 64'(s_cyc), 64'd0);
    chk("drain_err_single", 64'(m_err), 64'd0);
    #1 step_masters();
    wait_done(50, "timeout_drain");
    wait_n = 0;
`else
    // Without the timeout feature err never asserts, even on a long stall.
    wait_n = 20;
    add_job(2, 1, 32'h0000_7000, 32'h77, 1'b1, 4'hF);
    exp_grant(3'b100, -1);
    exp_ack(3'b100, 3'b100, 3'b000, 32'h0BAD_F00D, 32'h7000, 32'h77, 1'b1, 4'hF);
    wait_done(100, "long_stall");
    wait_n = 0;
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Parametrised N-master to 1-slave Wishbone (classic, single-cycle handshake) round-robin arbiter for the user project area.
- Lets the management SoC slave port and the SERV core's instruction and data buses share one downstream Wishbone target, such as program RAM or a peripheral block.
- Replaces fixed point-to-point bus hookups with a generalised, fair, cycle-locked bus.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- SW, DW/8, byte-select width (derived; do not override)
- TIMEOUT_CYCLES, 255, cycles a strobe may wait for ack before error (used only with WB_ARB_TIMEOUT_EN; range 1..65535)

Ports:
- wb_clk_i  in  1  single clock for all logic
- wb_rst_i  in  1  synchronous, active-high reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_sel_i  in  NUM_MASTERS*SW  byte selects; master k occupies [k*SW +: SW]
- m_adr_i  in  NUM_MASTERS*AW  addresses, packed as above
- m_dat_i  in  NUM_MASTERS*DW  write data, packed as above
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master error (timeout)
- m_dat_o  out  DW  read data, broadcast to all masters
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_sel_o  out  SW  slave byte selects
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_ack_i  in  1  slave ack
- s_dat_i  in  DW  slave read data
- grant_o  out  NUM_MASTERS  one-hot registered grant (zero when idle)
- busy_o  out  1  high when any master is granted

Behaviour:
- Reset (wb_rst_i high at a clock edge):
  - state := IDLE, grant_o := 0, rr_ptr := NUM_MASTERS-1 (so master 0 wins first), timeout counter := 0.
  - All s_* outputs, m_ack_o, m_err_o and busy_o are 0 from the following cycle.
  - Reset mid-transfer aborts silently: no ack and no err is issued.
- States: IDLE, GRANT, DRAIN (DRAIN exists only with the macro).
- IDLE:
  - If any m_cyc_i bit is high, pick the first requester found searching upward from rr_ptr+1 modulo NUM_MASTERS.
  - Register the one-hot grant, set rr_ptr := winner index, go to GRANT.
  - Arbitration latency is exactly 1 cycle: request seen at edge t, s_cyc_o high during cycle t+1.
- GRANT:
  - s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g]; we/sel/adr/dat are muxed combinationally from the granted master.
  - m_ack_o[g] = s_ack_i & m_stb_i[g]; all other m_ack_o bits are 0.
  - Ack is combinational pass-through, adding zero latency on the data phase.
  - Grant is locked for the whole cycle: the master may issue multiple strobes back-to-back while m_cyc_i[g] stays high.
  - When m_cyc_i[g] is sampled low, go to IDLE with grant_o := 0. This gives one mandatory dead cycle between owners.
- Non-granted masters see ack=0 and err=0 and simply wait; requests are never dropped.
- m_dat_o = s_dat_i always (broadcast); masters qualify it with their own ack.
- s_ack_i while idle, or while s_stb_o is low, is ignored.
- Simultaneous release and request: a new owner is granted only from IDLE, never in the same cycle as the release.
- A single persistent requester with no competitors is re-granted after each dead cycle.
- NUM_MASTERS=1 degenerates to pass-through with the 1-cycle grant latency.

Optional Feature:
WB_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter increments each GRANT cycle with s_stb_o=1 and s_ack_i=0. It clears on any ack or state change.
  - When the count reaches TIMEOUT_CYCLES with no ack, assert m_err_o[g] for exactly 1 cycle. In that same cycle force s_cyc_o/s_stb_o to 0, and go to DRAIN.
  - DRAIN holds grant_o[g] with s_cyc_o=0 until m_cyc_i[g] is low, then goes to IDLE.
- Not defined: no counter and no DRAIN state; m_err_o is tied to 0; a hung slave stalls the bus indefinitely.

Test Plan:
- Reset then single request: m_cyc_i=3'b010 with strobe, adr 0x0000_1000, we=1, dat 0xDEADBEEF; s_ack_i on cycle 3 -> grant_o=3'b010 one cycle after request, s_adr_o=0x1000, s_dat_o=0xDEADBEEF, m_ack_o=3'b010 in the ack cycle only.
- All three masters requesting continuously, each doing 1-beat cycles -> grant order 0,1,2,0,1,2 with exactly one idle cycle between grants.
- Cycle lock: master 0 does 4 back-to-back strobes while master 2 requests -> master 2 is not granted until master 0 drops cyc; then master 2 gets grant_o=3'b100.
- Read data: slave returns s_dat_i=0xCAFE0001 with ack to master 1 -> m_dat_o=0xCAFE0001; m_ack_o=3'b010; masters 0 and 2 have ack=0.
- Reset asserted mid-transfer while granted -> next cycle grant_o=0, s_cyc_o=0, no ack/err pulse; the next request goes to master 0 first.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> m_err_o[g] pulses once on the 8th unacked strobe cycle, s_stb_o drops the same cycle, grant held until m_cyc_i[g] falls, then IDLE.
